// File: rtl/turfio_dout_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : turfio_dout_pkg
// Purpose  : Shared constants and types for the TURFIO output-lane mux:
//            default training/idle bytes, arbiter state encoding and a small
//            counter-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package turfio_dout_pkg;

    // Byte sent on every lane while the link is being trained.
    localparam logic [7:0] c_train_value = 8'h6A;
    // Byte sent when no source has a byte ready.
    localparam logic [7:0] c_idle_value  = 8'h00;

    // Packet arbiter states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOCK_DAT = 2'd1,
        ST_LOCK_REG = 2'd2
    } dout_state_t;

    // Width of a counter holding 0..n-1; never narrower than one bit so a
    // single-phase configuration still has a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/turfio_dout_lane.sv
`default_nettype none
// ============================================================================
// Module   : turfio_dout_lane
// Purpose  : One output lane: an 8-bit load/shift register that sends its
//            byte LSB-first, BPC bits per cycle, with optional polarity
//            inversion. The lane output comes straight from a flop.
// Ports    : clk     - interface clock
//            rst_n   - asynchronous active-low reset
//            i_load  - load i_byte on this edge instead of shifting
//            i_byte  - byte to load
//            o_dout  - BPC-bit slice for the serializer (inverted if INV)
// Revision : 1.0 - initial release
// ============================================================================
module turfio_dout_lane
    import turfio_dout_pkg::*;
#(
    parameter int         BPC        = 4,
    parameter logic [7:0] IDLE_VALUE = c_idle_value,
    parameter logic       INV        = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_load,
    input  logic [7:0]     i_byte,
    output logic [BPC-1:0] o_dout
);

    localparam logic [BPC-1:0] c_inv_bits = {BPC{INV}};

    logic [7:0]     r_shreg;
    logic [BPC-1:0] r_dout;
    logic [7:0]     w_shreg_next;

    always_comb begin
        w_shreg_next = i_load ? i_byte : (r_shreg >> BPC);
    end

    // The output flop is fed from the next shift-register value so the
    // serializer sees the new byte's first slice the cycle after the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= IDLE_VALUE;
            r_dout  <= IDLE_VALUE[BPC-1:0] ^ c_inv_bits;
        end else begin
            r_shreg <= w_shreg_next;
            r_dout  <= w_shreg_next[BPC-1:0] ^ c_inv_bits;
        end
    end

    assign o_dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/turfio_dout_mux.sv
`default_nettype none
// ============================================================================
// Module   : turfio_dout_mux
// Purpose  : Packet-locked mux of an event-data stream and a register-response
//            stream onto NLANES byte lanes, serialized BPC bits per ifclk
//            cycle. Training overrides everything; idle bytes fill gaps.
// Ports    : ifclk_i       - interface clock (single domain)
//            ifclk_rstn_i  - asynchronous active-low reset
//            ifclk_sync_i  - one-cycle frame-start pulse, realigns byte phase
//            train_i       - force TRAIN_VALUE on all lanes
//            s_dat_*       - event-data AXI-stream slave (8*NLANES wide)
//            s_reg_*       - register-response AXI-stream slave
//            dout_o        - NLANES*BPC parallel word to the serializer
//            busy_o        - a packet is locked
//            src_o         - locked source: 0 = dat, 1 = reg
// Revision : 1.0 - initial release
// ============================================================================
module turfio_dout_mux
    import turfio_dout_pkg::*;
#(
    parameter int                NLANES      = 1,
    parameter int                BPC         = 4,
    parameter logic [7:0]        TRAIN_VALUE = c_train_value,
    parameter logic [7:0]        IDLE_VALUE  = c_idle_value,
    parameter logic [NLANES-1:0] INV_MASK    = {NLANES{1'b0}}
) (
    input  logic                    ifclk_i,
    input  logic                    ifclk_rstn_i,
    input  logic                    ifclk_sync_i,
    input  logic                    train_i,

    input  logic [8*NLANES-1:0]     s_dat_tdata,
    input  logic                    s_dat_tvalid,
    input  logic                    s_dat_tlast,
    output logic                    s_dat_tready,

    input  logic [8*NLANES-1:0]     s_reg_tdata,
    input  logic                    s_reg_tvalid,
    input  logic                    s_reg_tlast,
    output logic                    s_reg_tready,

    output logic [NLANES*BPC-1:0]   dout_o,
    output logic                    busy_o,
    output logic                    src_o
);

    // BPC must be 2, 4 or 8 so that a byte divides evenly into phases.
    localparam int              c_nph        = 8 / BPC;
    localparam int              c_pw         = cnt_width(c_nph);
    localparam logic [c_pw-1:0] c_last_phase = c_pw'(c_nph - 1);

    logic [c_pw-1:0] r_phase;
    logic            r_sync_q;
    logic            r_train_q;
    logic            r_live;
    dout_state_t     r_state;
    logic            r_busy;
    logic            r_src;

    logic                w_byte_end;
    logic                w_sync_hit;
    logic                w_slot_open;
    logic                w_acc_dat;
    logic                w_acc_reg;
    logic                w_lane_load;
    logic [8*NLANES-1:0] w_load_word;

    // ------------------------------------------------------------------
    // Byte phase, sync and training capture
    // ------------------------------------------------------------------
    assign w_byte_end = (r_phase == c_last_phase);
    // With one phase per byte there is nothing to realign, so sync is inert.
    assign w_sync_hit = (c_nph > 1) ? r_sync_q : 1'b0;
    // r_live keeps tready low on the first cycle out of reset; otherwise a
    // single-phase build would offer a slot while still held in reset.
    assign w_slot_open = w_byte_end && r_live && !w_sync_hit && !r_train_q;

    always_ff @(posedge ifclk_i or negedge ifclk_rstn_i) begin
        if (!ifclk_rstn_i) begin
            r_phase   <= '0;
            r_sync_q  <= 1'b0;
            r_train_q <= 1'b0;
            r_live    <= 1'b0;
        end else begin
            r_sync_q  <= ifclk_sync_i;
            r_train_q <= train_i;
            r_live    <= 1'b1;
            if (r_sync_q || w_byte_end) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Ready generation: at most one source is offered the slot
    // ------------------------------------------------------------------
    always_comb begin
        s_dat_tready = 1'b0;
        s_reg_tready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Register responses win a fresh arbitration.
                s_reg_tready = w_slot_open;
                s_dat_tready = w_slot_open && !s_reg_tvalid;
            end
            ST_LOCK_DAT: s_dat_tready = w_slot_open;
            ST_LOCK_REG: s_reg_tready = w_slot_open;
            default: ;
        endcase
    end

    assign w_acc_dat = s_dat_tready && s_dat_tvalid;
    assign w_acc_reg = s_reg_tready && s_reg_tvalid;

    // ------------------------------------------------------------------
    // Byte selection for the lane registers
    // ------------------------------------------------------------------
    // A sync forces a reload so the partial byte in flight is replaced by
    // idle and the new frame starts on a clean byte boundary.
    assign w_lane_load = w_byte_end || w_sync_hit;

    always_comb begin
        w_load_word = {NLANES{IDLE_VALUE}};
        if (w_sync_hit) begin
            w_load_word = {NLANES{IDLE_VALUE}};
        end else if (r_train_q) begin
            w_load_word = {NLANES{TRAIN_VALUE}};
        end else if (w_acc_reg) begin
            w_load_word = s_reg_tdata;
        end else if (w_acc_dat) begin
            w_load_word = s_dat_tdata;
        end
    end

    // ------------------------------------------------------------------
    // Packet arbiter
    // ------------------------------------------------------------------
    always_ff @(posedge ifclk_i or negedge ifclk_rstn_i) begin
        if (!ifclk_rstn_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_src   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A single-beat packet never needs a lock.
                    if (w_acc_reg && !s_reg_tlast) begin
                        r_state <= ST_LOCK_REG;
                        r_busy  <= 1'b1;
                        r_src   <= 1'b1;
                    end else if (w_acc_dat && !s_dat_tlast) begin
                        r_state <= ST_LOCK_DAT;
                        r_busy  <= 1'b1;
                        r_src   <= 1'b0;
                    end
                end
                ST_LOCK_DAT: begin
                    if (w_acc_dat && s_dat_tlast) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_src   <= 1'b0;
                    end
                end
                ST_LOCK_REG: begin
                    if (w_acc_reg && s_reg_tlast) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_src   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_src   <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = r_busy;
    assign src_o  = r_src;

    // ------------------------------------------------------------------
    // Output lanes
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        turfio_dout_lane #(
            .BPC        (BPC),
            .IDLE_VALUE (IDLE_VALUE),
            .INV        (INV_MASK[k])
        ) u_lane (
            .clk    (ifclk_i),
            .rst_n  (ifclk_rstn_i),
            .i_load (w_lane_load),
            .i_byte (w_load_word[8*k +: 8]),
            .o_dout (dout_o[BPC*k +: BPC])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_turfio_dout_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_turfio_dout_mux
// Purpose  : Self-checking bench. A randomized main instance (2 lanes, 4 bits
//            per cycle, lane 1 inverted) is compared every cycle with a
//            byte-slot reference model; two small directed instances cover
//            the 2-bit and 8-bit lane widths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_turfio_dout_mux;

    localparam int         NL    = 2;
    localparam int         BPC   = 4;
    localparam int         NPH   = 8 / BPC;
    localparam logic [1:0] INV   = 2'b10;
    localparam logic [7:0] TRAIN = 8'h6A;
    localparam logic [7:0] IDLE  = 8'h00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // main instance
    logic        sync, train;
    logic [15:0] dat_data, reg_data;
    logic        dat_valid, dat_last, reg_valid, reg_last;
    logic        dat_ready, reg_ready, busy, src;
    logic [7:0]  dout;

    // 2-bit instance
    logic [7:0]  d2_data;
    logic        d2_valid, d2_last, d2_ready, d2_reg_ready, d2_busy, d2_src;
    logic [1:0]  d2_dout;

    // 8-bit two-lane instance
    logic [15:0] d8_data;
    logic        d8_valid, d8_last, d8_ready, d8_reg_ready, d8_busy, d8_src;
    logic [15:0] d8_dout;

    turfio_dout_mux #(.NLANES(NL), .BPC(BPC), .INV_MASK(INV)) u_dut (
        .ifclk_i(clk), .ifclk_rstn_i(rst_n), .ifclk_sync_i(sync), .train_i(train),
        .s_dat_tdata(dat_data), .s_dat_tvalid(dat_valid), .s_dat_tlast(dat_last), .s_dat_tready(dat_ready),
        .s_reg_tdata(reg_data), .s_reg_tvalid(reg_valid), .s_reg_tlast(reg_last), .s_reg_tready(reg_ready),
        .dout_o(dout), .busy_o(busy), .src_o(src)
    );

    turfio_dout_mux #(.NLANES(1), .BPC(2), .INV_MASK(1'b0)) u_dut2 (
        .ifclk_i(clk), .ifclk_rstn_i(rst_n), .ifclk_sync_i(1'b0), .train_i(1'b0),
        .s_dat_tdata(d2_data), .s_dat_tvalid(d2_valid), .s_dat_tlast(d2_last), .s_dat_tready(d2_ready),
        .s_reg_tdata(8'h00), .s_reg_tvalid(1'b0), .s_reg_tlast(1'b0), .s_reg_tready(d2_reg_ready),
        .dout_o(d2_dout), .busy_o(d2_busy), .src_o(d2_src)
    );

    turfio_dout_mux #(.NLANES(2), .BPC(8), .INV_MASK(2'b10)) u_dut8 (
        .ifclk_i(clk), .ifclk_rstn_i(rst_n), .ifclk_sync_i(1'b0), .train_i(1'b0),
        .s_dat_tdata(d8_data), .s_dat_tvalid(d8_valid), .s_dat_tlast(d8_last), .s_dat_tready(d8_ready),
        .s_reg_tdata(16'h0000), .s_reg_tvalid(1'b0), .s_reg_tlast(1'b0), .s_reg_tready(d8_reg_ready),
        .dout_o(d8_dout), .busy_o(d8_busy), .src_o(d8_src)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks the byte being shown on the wire and which
    // slice of it is visible, plus the packet lock, in slot terms.
    // ------------------------------------------------------------------
    int          m_phase;    // cycles since last byte boundary
    bit          m_sync_q, m_train_q, m_live;
    int          m_lock;     // 0 none, 1 dat, 2 reg
    logic [15:0] m_word;     // bytes currently on the lanes
    int          m_pos;      // slice index being shown
    bit          reset_pending;
    int          dat_left, reg_left;

    task automatic model_reset();
        m_phase = 0; m_sync_q = 0; m_train_q = 0; m_live = 0;
        m_lock = 0; m_word = {2{IDLE}}; m_pos = 0;
    endtask

    function automatic logic [7:0] exp_dout();
        logic [7:0] b, r, res;
        logic [1:0] inv;
        inv = INV;
        res = '0;
        for (int k = 0; k < NL; k++) begin
            b = m_word[8*k +: 8];
            r = b >> (BPC * m_pos);
            res[4*k +: 4] = r[3:0] ^ {4{inv[k]}};
        end
        return res;
    endfunction

    task automatic next_beat(input bit accepted, inout logic valid, inout logic [15:0] data,
                             inout logic last, inout int left);
        if (accepted) begin
            valid = 1'b0;
            left--;
        end
        if (!valid && $urandom_range(0, 3) != 0) begin
            if (left == 0) left = $urandom_range(1, 4);
            valid = 1'b1;
            data  = 16'($urandom);
            last  = (left == 1);
        end
    endtask

    task automatic main_cycle();
        bit boundary, sync_hit, open, e_reg, e_dat, acc_reg, acc_dat;
        @(negedge clk);
        boundary = (m_phase == NPH - 1);
        sync_hit = m_sync_q && (NPH > 1);
        open     = boundary && m_live && !sync_hit && !m_train_q;
        e_reg    = open && (m_lock != 1);
        e_dat    = open && (m_lock == 1 || (m_lock == 0 && !reg_valid));
        chk_eq("reg_tready", 32'(reg_ready), 32'(e_reg));
        chk_eq("dat_tready", 32'(dat_ready), 32'(e_dat));
        chk_eq("busy", 32'(busy), 32'(m_lock != 0));
        chk_eq("src", 32'(src), 32'(m_lock == 2));
        chk_eq("dout", 32'(dout), 32'(exp_dout()));

        @(posedge clk);
        acc_reg = e_reg && reg_valid;
        acc_dat = e_dat && dat_valid;
        if (boundary || sync_hit) begin
            if (sync_hit)       m_word = {2{IDLE}};
            else if (m_train_q) m_word = {2{TRAIN}};
            else if (acc_reg)   m_word = reg_data;
            else if (acc_dat)   m_word = dat_data;
            else                m_word = {2{IDLE}};
            m_pos = 0;
        end else begin
            m_pos++;
        end
        if (m_lock == 0) begin
            if (acc_reg && !reg_last)      m_lock = 2;
            else if (acc_dat && !dat_last) m_lock = 1;
        end else if (m_lock == 1 && acc_dat && dat_last) begin
            m_lock = 0;
        end else if (m_lock == 2 && acc_reg && reg_last) begin
            m_lock = 0;
        end
        m_phase  = m_sync_q ? 0 : (m_phase + 1) % NPH;
        m_sync_q = sync;
        m_train_q = train;
        m_live   = 1;

        #1;
        next_beat(acc_reg, reg_valid, reg_data, reg_last, reg_left);
        next_beat(acc_dat, dat_valid, dat_data, dat_last, dat_left);
        sync = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 29) == 0) train = !train;

        // Asynchronous reset pulse inside a load cycle.
        if (reset_pending && m_phase == NPH - 1) begin
            #1 rst_n = 1'b0;
            #1;
            chk_eq("rst_dout", 32'(dout), 32'h0000_00F0);
            chk_eq("rst_busy", 32'(busy), 32'd0);
            chk_eq("rst_src", 32'(src), 32'd0);
            chk_eq("rst_readys", 32'({reg_ready, dat_ready}), 32'd0);
            model_reset();
            #1 rst_n = 1'b1;
            reset_pending = 0;
        end
    endtask

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic d2_wait_ready(input string tag);
        bit seen = 0;
        for (int w = 0; w < 12 && !seen; w++) begin
            @(negedge clk);
            if (d2_ready) seen = 1;
        end
        chk_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic d8_send(input logic [15:0] d, input bit last,
                           input logic [15:0] exp_d, input bit exp_busy);
        bit seen = 0;
        d8_data = d; d8_last = last; d8_valid = 1'b1;
        for (int w = 0; w < 6 && !seen; w++) begin
            @(negedge clk);
            if (d8_ready) seen = 1;
        end
        chk_eq("d8_ready_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1 d8_valid = 1'b0;
        @(negedge clk);
        chk_eq("d8_dout", 32'(d8_dout), 32'(exp_d));
        chk_eq("d8_busy", 32'(d8_busy), 32'(exp_busy));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b1, b2, sh;
        rst_n = 1'b0;
        sync = 0; train = 0;
        dat_data = '0; reg_data = '0; dat_valid = 0; reg_valid = 0; dat_last = 0; reg_last = 0;
        d2_data = '0; d2_valid = 0; d2_last = 0;
        d8_data = '0; d8_valid = 0; d8_last = 0;
        dat_left = 0; reg_left = 0; reset_pending = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk_eq("init_dout", 32'(dout), 32'h0000_00F0);
        chk_eq("init_busy_src", 32'({busy, src}), 32'd0);
        chk_eq("init_readys", 32'({reg_ready, dat_ready}), 32'd0);
        chk_eq("init_d8_dout", 32'(d8_dout), 32'h0000_FF00);
        chk_eq("init_d8_ready", 32'(d8_ready), 32'd0);
        chk_eq("init_d2_dout", 32'(d2_dout), 32'd0);
        rst_n = 1'b1;

        // 2 bits per cycle: 0x1B then 0xE4 (last)
        b1 = 8'h1B; b2 = 8'hE4;
        d2_data = b1; d2_last = 1'b0; d2_valid = 1'b1;
        d2_wait_ready("d2_beat1_ready");
        @(posedge clk);
        #1 d2_data = b2; d2_last = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            sh = b1 >> (2 * j);
            chk_eq("d2_dout_b1", 32'(d2_dout), 32'(sh[1:0]));
            chk_eq("d2_busy_b1", 32'(d2_busy), 32'd1);
            if (j == 3) chk_eq("d2_beat2_ready", 32'(d2_ready), 32'd1);
        end
        @(posedge clk);
        #1 d2_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            sh = b2 >> (2 * j);
            chk_eq("d2_dout_b2", 32'(d2_dout), 32'(sh[1:0]));
            chk_eq("d2_busy_b2", 32'(d2_busy), 32'd0);
        end
        @(negedge clk);
        chk_eq("d2_dout_idle", 32'(d2_dout), 32'd0);

        // 8 bits per cycle, two lanes, lane 1 inverted
        d8_send(16'h0F0F, 1'b1, 16'hF00F, 1'b0);
        @(negedge clk);
        chk_eq("d8_dout_idle", 32'(d8_dout), 32'h0000_FF00);
        d8_send(16'h1234, 1'b0, 16'hED34, 1'b1);
        d8_send(16'h5678, 1'b1, 16'hA978, 1'b0);

        // Randomized run on the main instance, from a fresh reset.
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 150) reset_pending = 1;
            main_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
